// File: rtl/reg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_ctrl_pkg
//  Description : Shared defaults, zero-register index and controller states.
//  Revision    : 1.0
// ============================================================================
package reg_ctrl_pkg;

    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;
    localparam int ZERO_REG  = 0;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/reg_write_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_ctrl_if
//  Description : Writeback, long-latency result, register-file write port and
//                hazard-unit status signals of the write-port controller.
//  Revision    : 1.0
// ============================================================================
interface reg_write_ctrl_if #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;
    logic             mc_valid;
    logic [AW-1:0]    mc_addr;
    logic [DW-1:0]    mc_data;
    logic             mc_ready;
    logic             mc_issue;
    logic [AW-1:0]    mc_issue_rd;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic             init_busy;
    logic [NREGS-1:0] pend_mask;
    logic             mc_starve;

    // Pipeline / long-latency side
    modport master (
        output wb_en, wb_addr, wb_data,
        output mc_valid, mc_addr, mc_data, mc_issue, mc_issue_rd,
        input  mc_ready, rf_we, rf_waddr, rf_wdata,
        input  init_busy, pend_mask, mc_starve
    );

    // Controller side
    modport slave (
        input  wb_en, wb_addr, wb_data,
        input  mc_valid, mc_addr, mc_data, mc_issue, mc_issue_rd,
        output mc_ready, rf_we, rf_waddr, rf_wdata,
        output init_busy, pend_mask, mc_starve
    );
endinterface
`default_nettype wire

// File: rtl/reg_pend_sb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_pend_sb
//  Description : Pending-write scoreboard, one bit per register, set beats
//                clear, x0 never pending.
//  Revision    : 1.0
// ============================================================================
module reg_pend_sb
    import reg_ctrl_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = AW_DEF
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             set_en,
    input  wire logic [AW-1:0]    set_addr,
    input  wire logic             clr_en,
    input  wire logic [AW-1:0]    clr_addr,
    output logic      [NREGS-1:0] mask
);

    for (genvar i = 0; i < NREGS; i++) begin : g_bit
        if (i == ZERO_REG) begin : g_zero
            assign mask[i] = 1'b0;
        end else begin : g_flop
            logic r_bit;
            always_ff @(posedge clk) begin
                if (!rst)
                    r_bit <= 1'b0;
                else if (set_en && (set_addr == AW'(i)))
                    r_bit <= 1'b1;
                else if (clr_en && (clr_addr == AW'(i)))
                    r_bit <= 1'b0;
            end
            assign mask[i] = r_bit;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_ctrl
//  Description : Register-file write-port controller: post-reset zero sweep,
//                WB-over-mc arbitration, pending scoreboard, starvation flag.
//  Revision    : 1.0
// ============================================================================
module reg_write_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int NREGS      = NREGS_DEF,
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_LIM = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    reg_write_ctrl_if.slave bus
);

    localparam int            SW          = $clog2(STARVE_LIM + 1);
    localparam logic [0:0]    c_st_init   = 1'(INIT);
    localparam logic [0:0]    c_st_run    = 1'(RUN);
    localparam logic [AW-1:0] c_last_addr = AW'(NREGS - 1);
    localparam logic [AW-1:0] c_zero_addr = AW'(ZERO_REG);
    localparam logic [SW-1:0] c_starve    = SW'(STARVE_LIM);

    logic [0:0]    r_state;
    logic [AW-1:0] r_init_cnt;
    logic [SW-1:0] r_starve_cnt;
    logic          w_run;
    logic          w_wb_req;
    logic          w_mc_grant;

    assign w_run    = (r_state == c_st_run);
    assign w_wb_req = bus.wb_en && (bus.wb_addr != c_zero_addr);

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        bus.mc_ready = 1'b0;
        w_mc_grant   = 1'b0;
        if (!w_run) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = r_init_cnt;
        end else if (w_wb_req) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.wb_addr;
            bus.rf_wdata = bus.wb_data;
        end else if (bus.mc_valid) begin
            // A result for x0 is still consumed, just not written.
            w_mc_grant   = 1'b1;
            bus.mc_ready = 1'b1;
            bus.rf_we    = (bus.mc_addr != c_zero_addr);
            bus.rf_waddr = bus.mc_addr;
            bus.rf_wdata = bus.mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_st_init;
            r_init_cnt   <= AW'(1);
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                c_st_init: begin
                    // Stop on the last register so the counter never wraps to x0.
                    if (r_init_cnt == c_last_addr)
                        r_state <= c_st_run;
                    else
                        r_init_cnt <= r_init_cnt + AW'(1);
                    r_starve_cnt <= '0;
                end
                default: begin
                    if (!bus.mc_valid || w_mc_grant)
                        r_starve_cnt <= '0;
                    else if (r_starve_cnt != c_starve)
                        r_starve_cnt <= r_starve_cnt + SW'(1);
                end
            endcase
        end
    end

    assign bus.init_busy = !w_run;
    assign bus.mc_starve = (r_starve_cnt == c_starve);

    reg_pend_sb #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_pend_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (w_run && bus.mc_issue),
        .set_addr (bus.mc_issue_rd),
        .clr_en   (w_mc_grant),
        .clr_addr (bus.mc_addr),
        .mask     (bus.pend_mask)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_ctrl
//  Description : Self-checking bench: vector table, directed corners and
//                random traffic against a behavioural model.
//  Revision    : 1.0
// ============================================================================
module tb_reg_write_ctrl;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_write_ctrl_if #(.NREGS(32), .AW(5), .DW(32)) bus ();

    reg_write_ctrl #(
        .NREGS      (32),
        .AW         (5),
        .DW         (32),
        .STARVE_LIM (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_init;
    int          m_cnt;
    logic [31:0] m_pend;
    int          m_denied;

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        mc_valid;
        logic [4:0]  mc_addr;
        logic [31:0] mc_data;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ready;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.mc_valid = 0; bus.mc_addr = 0; bus.mc_data = 0;
        bus.mc_issue = 0; bus.mc_issue_rd = 0;
    endtask

    task automatic model_reset();
        m_init = 1; m_cnt = 1; m_pend = 0; m_denied = 0;
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic cycle();
        logic        e_we, e_rdy;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        bit          grant;
        #1;
        e_we = 0; e_rdy = 0; e_addr = 0; e_data = 0;
        if (m_init) begin
            e_we = 1; e_addr = 5'(m_cnt);
        end else if (bus.wb_en && bus.wb_addr != 0) begin
            e_we = 1; e_addr = bus.wb_addr; e_data = bus.wb_data;
        end else if (bus.mc_valid) begin
            e_rdy = 1; e_we = (bus.mc_addr != 0); e_addr = bus.mc_addr; e_data = bus.mc_data;
        end
        chk("model rf_we", 32'(bus.rf_we), 32'(e_we));
        if (e_we) begin
            chk("model rf_waddr", 32'(bus.rf_waddr), 32'(e_addr));
            chk("model rf_wdata", bus.rf_wdata, e_data);
        end
        chk("model mc_ready", 32'(bus.mc_ready), 32'(e_rdy));
        chk("model init_busy", 32'(bus.init_busy), 32'(m_init));
        chk("model pend_mask", bus.pend_mask, m_pend);
        chk("model mc_starve", 32'(bus.mc_starve), 32'(m_denied >= 8));
        @(posedge clk);
        grant = e_rdy;
        if (!rst) begin
            model_reset();
        end else if (m_init) begin
            if (m_cnt == 31) m_init = 0;
            m_cnt++;
        end else begin
            if (grant) m_pend[bus.mc_addr] = 1'b0;
            if (bus.mc_issue) m_pend[bus.mc_issue_rd] = 1'b1;
            m_pend[0] = 1'b0;
            if (!bus.mc_valid || grant) m_denied = 0;
            else if (m_denied < 8) m_denied++;
        end
        #1;
    endtask

    initial begin
        vecs[0] = '{1, 5,  32'hDEADBEEF, 1, 7,  32'h11111111, 1, 5,  32'hDEADBEEF, 0};
        vecs[1] = '{0, 5,  32'h0,        1, 7,  32'h11111111, 1, 7,  32'h11111111, 1};
        vecs[2] = '{1, 0,  32'h12,       0, 0,  32'h0,        0, 0,  32'h0,        0};
        vecs[3] = '{0, 0,  32'h0,        1, 0,  32'h55,       0, 0,  32'h0,        1};
        vecs[4] = '{1, 0,  32'h99,       1, 12, 32'hA5A5A5A5, 1, 12, 32'hA5A5A5A5, 1};
        vecs[5] = '{0, 3,  32'h77,       0, 4,  32'h88,       0, 0,  32'h0,        0};
        vecs[6] = '{1, 31, 32'hFFFFFFFF, 0, 2,  32'h0,        1, 31, 32'hFFFFFFFF, 0};
        vecs[7] = '{1, 1,  32'h1,        1, 0,  32'h3,        1, 1,  32'h1,        0};

        idle();
        rst = 0;
        @(posedge clk);
        model_reset();
        #1;
        cycle();
        chk("reset rf_waddr", 32'(bus.rf_waddr), 1);
        chk("reset mc_starve", 32'(bus.mc_starve), 0);

        // Zero-fill sweep with requests that must be ignored
        rst = 1;
        bus.wb_en = 1; bus.wb_addr = 6; bus.wb_data = 32'h1234;
        bus.mc_valid = 1; bus.mc_addr = 8; bus.mc_issue = 1; bus.mc_issue_rd = 3;
        for (int i = 1; i <= 31; i++) begin
            #1;
            chk("sweep rf_waddr", 32'(bus.rf_waddr), 32'(i));
            chk("sweep rf_wdata", bus.rf_wdata, 0);
            chk("sweep mc_ready", 32'(bus.mc_ready), 0);
            cycle();
        end
        idle();
        #1;
        chk("sweep done init_busy", 32'(bus.init_busy), 0);
        chk("sweep pend_mask", bus.pend_mask, 0);

        // Vector table, combinational arbitration
        foreach (vecs[k]) begin
            bus.wb_en = vecs[k].wb_en; bus.wb_addr = vecs[k].wb_addr; bus.wb_data = vecs[k].wb_data;
            bus.mc_valid = vecs[k].mc_valid; bus.mc_addr = vecs[k].mc_addr; bus.mc_data = vecs[k].mc_data;
            #1;
            chk($sformatf("vec%0d rf_we", k), 32'(bus.rf_we), 32'(vecs[k].we));
            chk($sformatf("vec%0d mc_ready", k), 32'(bus.mc_ready), 32'(vecs[k].ready));
            if (vecs[k].we) begin
                chk($sformatf("vec%0d rf_waddr", k), 32'(bus.rf_waddr), 32'(vecs[k].waddr));
                chk($sformatf("vec%0d rf_wdata", k), bus.rf_wdata, vecs[k].wdata);
            end
            cycle();
        end
        idle();

        // Scoreboard set / clear / set-wins
        bus.mc_issue = 1; bus.mc_issue_rd = 9;
        cycle();
        idle();
        #1 chk("pend set x9", 32'(bus.pend_mask[9]), 1);
        bus.mc_valid = 1; bus.mc_addr = 9;
        cycle();
        idle();
        #1 chk("pend clear x9", 32'(bus.pend_mask[9]), 0);
        bus.mc_issue = 1; bus.mc_issue_rd = 9; bus.mc_valid = 1; bus.mc_addr = 9;
        cycle();
        idle();
        #1 chk("pend set wins", 32'(bus.pend_mask[9]), 1);

        // Starvation
        bus.wb_en = 1; bus.wb_addr = 4; bus.wb_data = 32'hCAFE;
        bus.mc_valid = 1; bus.mc_addr = 10; bus.mc_data = 32'hBEEF;
        for (int k = 1; k <= 9; k++) begin
            cycle();
            chk($sformatf("starve after %0d", k), 32'(bus.mc_starve), 32'(k >= 8));
        end
        bus.wb_en = 0;
        #1 chk("starve grant ready", 32'(bus.mc_ready), 1);
        cycle();
        idle();
        #1 chk("starve falls", 32'(bus.mc_starve), 0);

        // Mid-RUN reset
        chk("pre-reset pend", bus.pend_mask, 32'h00000200);
        rst = 0;
        cycle();
        rst = 1;
        #1;
        chk("post-reset pend", bus.pend_mask, 0);
        chk("post-reset busy", 32'(bus.init_busy), 1);
        chk("post-reset waddr", 32'(bus.rf_waddr), 1);
        for (int i = 0; i < 31; i++) cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            bus.wb_en = ($urandom_range(0, 2) != 0);
            bus.wb_addr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) bus.wb_addr = 0;
            bus.wb_data = $urandom;
            if (!bus.mc_valid || bus.mc_ready) begin
                bus.mc_valid = ($urandom_range(0, 1) != 0);
                bus.mc_addr = 5'($urandom_range(0, 31));
                bus.mc_data = $urandom;
            end
            bus.mc_issue = ($urandom_range(0, 2) == 0);
            bus.mc_issue_rd = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
